// File: rtl/payload_class_pkg.sv
// Shared constants for the payload feeder: character-class indices, the 256-bit
// class membership table, byte case folding and the feeder FSM state encoding.
package payload_class_pkg;

   localparam int NUM_CLASS = 80;

   localparam int CLS_DIGIT      = 0;
   localparam int CLS_WORD       = 1;
   localparam int CLS_SPACE      = 2;
   localparam int CLS_DOT        = 3;
   localparam int CLS_UPPER      = 4;
   localparam int CLS_LOWER      = 5;
   localparam int CLS_ALPHA      = 6;
   localparam int CLS_HEX        = 7;
   localparam int CLS_DASH       = 8;
   localparam int CLS_UNDERSCORE = 9;
   localparam int CLS_SLASH      = 10;
   localparam int CLS_COLON      = 11;
   localparam int CLS_CR         = 12;
   localparam int CLS_LF         = 13;
   localparam int CLS_HIGH       = 14;
   localparam int CLS_ANY        = 15;
   // Single-character literal classes: a..z, A..Z, 0..9
   localparam int CLS_LIT_LOWER  = 16;
   localparam int CLS_LIT_UPPER  = 42;
   localparam int CLS_LIT_DIGIT  = 68;
   localparam int CLS_AT         = 78;
   localparam int CLS_EQ         = 79;

   typedef logic [NUM_CLASS-1:0][255:0] class_table_t;

   typedef enum logic [2:0] {
      IDLE,
      SOD,
      STREAM,
      FLUSH,
      SETTLE,
      REPORT
   } feeder_state_t;

   function automatic logic [255:0] range_map(int lo, int hi);
      logic [256:0] m;
      m = ((257'd1 << (hi + 1)) - 257'd1) ^ ((257'd1 << lo) - 257'd1);
      return m[255:0];
   endfunction

   function automatic logic [255:0] char_map(int c);
      return range_map(c, c);
   endfunction

   function automatic logic [255:0] class_map(int idx);
      logic [255:0] digit;
      logic [255:0] upper;
      logic [255:0] lower;
      logic [255:0] m;
      digit = range_map('h30, 'h39);
      upper = range_map('h41, 'h5A);
      lower = range_map('h61, 'h7A);
      m     = '0;
      if (idx >= CLS_LIT_LOWER && idx < CLS_LIT_LOWER + 26)
         m = char_map('h61 + idx - CLS_LIT_LOWER);
      else if (idx >= CLS_LIT_UPPER && idx < CLS_LIT_UPPER + 26)
         m = char_map('h41 + idx - CLS_LIT_UPPER);
      else if (idx >= CLS_LIT_DIGIT && idx < CLS_LIT_DIGIT + 10)
         m = char_map('h30 + idx - CLS_LIT_DIGIT);
      else begin
         case (idx)
            CLS_DIGIT:      m = digit;
            CLS_WORD:       m = digit | upper | lower | char_map('h5F);
            CLS_SPACE:      m = range_map('h09, 'h0D) | char_map('h20);
            CLS_DOT:        m = char_map('h2E);
            CLS_UPPER:      m = upper;
            CLS_LOWER:      m = lower;
            CLS_ALPHA:      m = upper | lower;
            CLS_HEX:        m = digit | range_map('h41, 'h46) | range_map('h61, 'h66);
            CLS_DASH:       m = char_map('h2D);
            CLS_UNDERSCORE: m = char_map('h5F);
            CLS_SLASH:      m = char_map('h2F);
            CLS_COLON:      m = char_map('h3A);
            CLS_CR:         m = char_map('h0D);
            CLS_LF:         m = char_map('h0A);
            CLS_HIGH:       m = range_map('h80, 'hFF);
            CLS_ANY:        m = range_map(0, 255);
            CLS_AT:         m = char_map('h40);
            CLS_EQ:         m = char_map('h3D);
            default:        m = '0;
         endcase
      end
      return m;
   endfunction

   function automatic class_table_t build_class_table();
      class_table_t t;
      for (int c = 0; c < NUM_CLASS; c++)
         t[c] = class_map(c);
      return t;
   endfunction

   localparam class_table_t CLASS_TABLE = build_class_table();

   function automatic logic [7:0] fold_case(logic [7:0] b);
      return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
   endfunction

endpackage

// File: rtl/payload_class_lut.sv
// Combinational byte -> character-class vector lookup. Defining
// PAYLOAD_FEEDER_NOCASE_EN folds 'A'..'Z' onto 'a'..'z' before the lookup.
module payload_class_lut #(
   parameter int NUM_CLASS = payload_class_pkg::NUM_CLASS
) (
   input  logic [7:0]           data,
   output logic [NUM_CLASS-1:0] cls_vec
);
   import payload_class_pkg::*;

   logic [7:0] key;

`ifdef PAYLOAD_FEEDER_NOCASE_EN
   assign key = fold_case(data);
`else
   assign key = data;
`endif

   // Classes beyond the table width read as never-hit
   genvar gi;
   for (gi = 0; gi < NUM_CLASS; gi++) begin : g_cls
      if (gi < payload_class_pkg::NUM_CLASS) begin : g_tab
         assign cls_vec[gi] = CLASS_TABLE[gi][key];
      end else begin : g_pad
         assign cls_vec[gi] = 1'b0;
      end
   end

endmodule

// File: rtl/payload_feeder.sv
// Streams packet bytes as class vectors into the match engines, flushes them and
// reports the captured match vector per packet. Option: PAYLOAD_FEEDER_NOCASE_EN.
module payload_feeder #(
   parameter int NUM_CLASS = payload_class_pkg::NUM_CLASS,
   parameter int NUM_ENG   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [NUM_CLASS-1:0] cls,
   output logic                 en,
   output logic                 sod,
   input  logic [NUM_ENG-1:0]   match_in,
   output logic [NUM_ENG-1:0]   match_vec,
   output logic                 result_valid,
   input  logic                 result_ready
);
   import payload_class_pkg::*;

   feeder_state_t        state_reg, state_next;
   logic                 settle_wait_reg, settle_wait_next;
   logic [NUM_CLASS-1:0] cls_reg, cls_next;
   logic                 en_reg, en_next;
   logic                 sod_reg, sod_next;
   logic                 result_valid_reg, result_valid_next;
   logic [NUM_ENG-1:0]   match_vec_reg, match_vec_next;
   logic [NUM_CLASS-1:0] lut_cls;
   logic                 accept;

   payload_class_lut #(.NUM_CLASS(NUM_CLASS)) u_lut (
      .data    (s_data),
      .cls_vec (lut_cls)
   );

   assign s_ready      = (state_reg == STREAM);
   assign accept       = s_valid & s_ready;
   assign cls          = cls_reg;
   assign en           = en_reg;
   assign sod          = sod_reg;
   assign match_vec    = match_vec_reg;
   assign result_valid = result_valid_reg;

   // sod resets high so every engine is held clear until the first edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         settle_wait_reg  <= 1'b0;
         cls_reg          <= '0;
         en_reg           <= 1'b0;
         sod_reg          <= 1'b1;
         result_valid_reg <= 1'b0;
         match_vec_reg    <= '0;
      end else begin
         state_reg        <= state_next;
         settle_wait_reg  <= settle_wait_next;
         cls_reg          <= cls_next;
         en_reg           <= en_next;
         sod_reg          <= sod_next;
         result_valid_reg <= result_valid_next;
         match_vec_reg    <= match_vec_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      settle_wait_next  = 1'b0;
      cls_next          = '0;
      en_next           = 1'b0;
      sod_next          = 1'b0;
      result_valid_next = result_valid_reg;
      match_vec_next    = match_vec_reg;
      case (state_reg)
         IDLE: begin
            if (s_valid) begin
               state_next = SOD;
               sod_next   = 1'b1;
            end
         end
         SOD: state_next = STREAM;
         STREAM: begin
            if (accept) begin
               en_next  = 1'b1;
               cls_next = lut_cls;
               if (s_last)
                  state_next = FLUSH;
            end
         end
         // Empty enable cycle lets the engines' end-state flops capture
         FLUSH: begin
            en_next    = 1'b1;
            state_next = SETTLE;
         end
         // Two idle cycles: engine outputs reflect the flush only after it lands
         SETTLE: begin
            if (settle_wait_reg) begin
               match_vec_next    = match_in;
               result_valid_next = 1'b1;
               state_next        = REPORT;
            end else begin
               settle_wait_next = 1'b1;
            end
         end
         REPORT: begin
            if (result_ready) begin
               result_valid_next = 1'b0;
               state_next        = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_payload_feeder.sv
// Bench for payload_feeder: a model regex engine on match_in[0], a dot-seen
// engine on match_in[1], and a queue of expected per-packet match vectors.
module tb_payload_feeder;
    import payload_class_pkg::*;

    localparam int NENG = 64;
    localparam int NTOK = 20;

    logic                 clk;
    logic                 rst_n;
    logic [7:0]           s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic [NUM_CLASS-1:0] cls;
    logic                 en;
    logic                 sod;
    logic [NENG-1:0]      match_in;
    logic [NENG-1:0]      match_vec;
    logic                 result_valid;
    logic                 result_ready;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    logic [63:0] exp_q[$];

    payload_feeder #(.NUM_CLASS(NUM_CLASS), .NUM_ENG(NENG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .cls          (cls),
        .en           (en),
        .sod          (sod),
        .match_in     (match_in),
        .match_vec    (match_vec),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Model engine, anchored NFA, case-insensitive: "STOR", one or more spaces,
    // "FKS_", word chars, "_", digits, "-", digits, "-", digits, a dot, "log"
    logic [6:0]  tok_a [NTOK];
    logic [6:0]  tok_b [NTOK];
    logic        tok_plus [NTOK];
    logic [NTOK:0] act_reg, act_next;
    logic        eng_hit_reg, dot_seen_reg;

    task automatic set_lit(input int i, input logic [7:0] ch);
        tok_a[i]    = 7'(CLS_LIT_LOWER) + 7'(ch - 8'h61);
        tok_b[i]    = 7'(CLS_LIT_UPPER) + 7'(ch - 8'h61);
        tok_plus[i] = 1'b0;
    endtask

    task automatic set_cls(input int i, input int c, input logic plus);
        tok_a[i]    = 7'(c);
        tok_b[i]    = 7'(c);
        tok_plus[i] = plus;
    endtask

    initial begin
        set_lit(0, "s");  set_lit(1, "t");  set_lit(2, "o");  set_lit(3, "r");
        set_cls(4, CLS_SPACE, 1'b1);
        set_lit(5, "f");  set_lit(6, "k");  set_lit(7, "s");
        set_cls(8, CLS_UNDERSCORE, 1'b0);  set_cls(9, CLS_WORD, 1'b1);
        set_cls(10, CLS_UNDERSCORE, 1'b0); set_cls(11, CLS_DIGIT, 1'b1);
        set_cls(12, CLS_DASH, 1'b0);       set_cls(13, CLS_DIGIT, 1'b1);
        set_cls(14, CLS_DASH, 1'b0);       set_cls(15, CLS_DIGIT, 1'b1);
        set_cls(16, CLS_DOT, 1'b0);
        set_lit(17, "l"); set_lit(18, "o"); set_lit(19, "g");
    end

    always_comb begin
        act_next = '0;
        for (int i = 0; i < NTOK; i++)
            if (cls[tok_a[i]] || cls[tok_b[i]])
                act_next[i+1] = act_reg[i] | (tok_plus[i] & act_reg[i+1]);
    end

    always @(posedge clk) begin
        if (sod) begin
            act_reg      <= '0;
            act_reg[0]   <= 1'b1;
            eng_hit_reg  <= 1'b0;
            dot_seen_reg <= 1'b0;
        end else if (en) begin
            act_reg <= act_next;
            if (act_next[NTOK]) eng_hit_reg <= 1'b1;
            if (cls[CLS_DOT])   dot_seen_reg <= 1'b1;
        end
    end

    assign match_in = {{(NENG-2){1'b0}}, dot_seen_reg, eng_hit_reg};

    // Independent class model for the expected cls bus
    function automatic logic [NUM_CLASS-1:0] exp_cls(input logic [7:0] raw);
        logic [7:0] b;
        logic [NUM_CLASS-1:0] v;
        logic isu, isl, isd;
        b = raw;
`ifdef PAYLOAD_FEEDER_NOCASE_EN
        if (raw >= 8'h41 && raw <= 8'h5A) b = raw + 8'h20;
`endif
        isu = (b >= 8'h41 && b <= 8'h5A);
        isl = (b >= 8'h61 && b <= 8'h7A);
        isd = (b >= 8'h30 && b <= 8'h39);
        v = '0;
        v[CLS_DIGIT]      = isd;
        v[CLS_WORD]       = isu | isl | isd | (b == 8'h5F);
        v[CLS_SPACE]      = (b == 8'h20) || (b >= 8'h09 && b <= 8'h0D);
        v[CLS_DOT]        = (b == 8'h2E);
        v[CLS_UPPER]      = isu;
        v[CLS_LOWER]      = isl;
        v[CLS_ALPHA]      = isu | isl;
        v[CLS_HEX]        = isd || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
        v[CLS_DASH]       = (b == 8'h2D);
        v[CLS_UNDERSCORE] = (b == 8'h5F);
        v[CLS_SLASH]      = (b == 8'h2F);
        v[CLS_COLON]      = (b == 8'h3A);
        v[CLS_CR]         = (b == 8'h0D);
        v[CLS_LF]         = (b == 8'h0A);
        v[CLS_HIGH]       = b[7];
        v[CLS_ANY]        = 1'b1;
        v[CLS_AT]         = (b == 8'h40);
        v[CLS_EQ]         = (b == 8'h3D);
        if (isl) v[7'(CLS_LIT_LOWER) + 7'(b - 8'h61)] = 1'b1;
        if (isu) v[7'(CLS_LIT_UPPER) + 7'(b - 8'h41)] = 1'b1;
        if (isd) v[7'(CLS_LIT_DIGIT) + 7'(b - 8'h30)] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_packet(input string s, input bit gaps, input int hold,
                               input logic [63:0] exp_mv);
        int k;
        int waited;
        logic [7:0]  b;
        logic [63:0] mv;
        k = 0;
        exp_q.push_back(exp_mv);
        for (int i = 0; i < s.len(); i++) begin
            b       = s[i];
            s_data  = b;
            s_last  = (i == s.len() - 1);
            s_valid = 1'b1;
            if (i == 0) begin
                @(posedge clk); #1;
                check("sod_start", 128'(sod), 128'(1));
                check("sod_ready", 128'(s_ready), 128'(0));
            end
            waited = 0;
            @(negedge clk);
            while (!s_ready && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            if (!s_ready) begin
                check("accept_timeout", 128'(0), 128'(1));
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
            k = edge_cnt;
            s_valid = 1'b0;
            check("en_acc", 128'(en), 128'(1));
            check("cls_acc", 128'(cls), 128'(exp_cls(b)));
            if (gaps && i != s.len() - 1) begin
                @(posedge clk); #1;
                check("en_gap", 128'(en), 128'(0));
                check("cls_gap", 128'(cls), 128'(0));
            end
        end
        s_last = 1'b0;
        @(posedge clk); #1;
        check("flush_en", 128'(en), 128'(1));
        check("flush_cls", 128'(cls), 128'(0));
        check("flush_ready", 128'(s_ready), 128'(0));
        check("rv_early", 128'(result_valid), 128'(0));
        @(posedge clk); #1;
        check("settle_en", 128'(en), 128'(0));
        waited = 0;
        while (!result_valid && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("rv_edge", 128'(edge_cnt - k), 128'(3));
        mv = exp_q.pop_front();
        check("match_vec", 128'(match_vec), 128'(mv));
        $display("pkt \"%s\" gaps=%0d match_vec=%0h expected=%0h", s, gaps, match_vec, mv);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_mv", 128'(match_vec), 128'(mv));
            check("hold_rv", 128'(result_valid), 128'(1));
            check("hold_ready", 128'(s_ready), 128'(0));
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("rv_clear", 128'(result_valid), 128'(0));
    endtask

    initial begin
        rst_n        = 1'b1;
        s_data       = 8'h00;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        result_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_sod", 128'(sod), 128'(1));
        end
        check("rst_en", 128'(en), 128'(0));
        check("rst_cls", 128'(cls), 128'(0));
        check("rst_ready", 128'(s_ready), 128'(0));
        check("rst_mv", 128'(match_vec), 128'(0));
        check("rst_rv", 128'(result_valid), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("sod_fall", 128'(sod), 128'(0));
        check("post_en", 128'(en), 128'(0));
        check("post_rv", 128'(result_valid), 128'(0));
        $display("reset released");

        send_packet("STOR FKS_ab_1-2-3.log", 1'b0, 0, 64'h3);
        send_packet("STOR FKS_ab_1-2-3.lox", 1'b0, 0, 64'h2);
        send_packet("S", 1'b0, 0, 64'h0);
        send_packet("STOR FKS_ab_1-2-3.log", 1'b1, 10, 64'h3);
        send_packet("stor\tfks_AB_12-3-45.LOG", 1'b0, 0, 64'h3);

        // Reset in the middle of a packet: nothing may be reported
        s_data  = 8'h53;
        s_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("mid_en", 128'(en), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", 128'(en), 128'(0));
        check("mid_rst_sod", 128'(sod), 128'(1));
        check("mid_rst_ready", 128'(s_ready), 128'(0));
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("mid_no_result", 128'(result_valid), 128'(0));
        end
        $display("reset mid-packet, packet discarded");

        send_packet("STOR FKS_ab_1-2-3.log", 1'b0, 0, 64'h3);

        check("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/payload_feeder.md
PAYLOAD_FEEDER -- requirements
Module: payload_feeder

Interface
REQ-001 Parameter NUM_CLASS, default 80: width of the character-class match bus driven to the engines.
REQ-002 Parameter NUM_ENG, default 64: number of engine match outputs collected.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 s_data  input  8  payload byte.
REQ-006 s_valid  input  1  byte valid.
REQ-007 s_last  input  1  marks the final byte of the packet.
REQ-008 s_ready  output  1  byte accepted on an edge where s_valid and s_ready are both 1.
REQ-009 cls  output  NUM_CLASS  registered one-hot-or-multi class hits for the current byte; bit i drives in_i of every engine.
REQ-010 en  output  1  engine clock enable.
REQ-011 sod  output  1  start-of-data clear to every engine.
REQ-012 match_in  input  NUM_ENG  engine out bits.
REQ-013 match_vec  output  NUM_ENG  per-packet captured match result.
REQ-014 result_valid  output  1  match_vec valid.
REQ-015 result_ready  input  1  result consumed on an edge where result_valid and result_ready are both 1.

Function
REQ-016 FSM states SHALL be IDLE, SOD, STREAM, FLUSH, SETTLE and REPORT.
REQ-017 IDLE: s_ready=0, en=0; on s_valid=1 go to SOD.
REQ-018 SOD: sod=1 for exactly one cycle, en=0, s_ready=0; then go to STREAM.
REQ-019 STREAM: s_ready=1; on each accepted byte, at that edge cls<=lut(byte) and en<=1; on a non-accepting edge en<=0 and cls<=0.
REQ-020 An accepted byte with s_last=1 SHALL move the FSM to FLUSH at the same edge.
REQ-021 FLUSH: one cycle with en=1, cls=0 so the engine end-state flops capture; s_ready=0; then go to SETTLE.
REQ-022 SETTLE: en=0; at the exiting edge match_vec<=match_in and result_valid<=1; go to REPORT.
REQ-023 Timing: with the last byte accepted at edge k, FLUSH SHALL run k+1..k+2 and result_valid SHALL rise at edge k+3.
REQ-024 REPORT: hold match_vec and result_valid stable and keep s_ready=0 until result_ready=1, then clear result_valid and go to IDLE.
REQ-025 A single-byte packet (s_last on the first byte) SHALL follow the same sequence.
REQ-026 s_valid dropping mid-packet SHALL insert en=0 bubbles only; engine state SHALL be preserved.

Reset
REQ-027 While rst_n=0: state=IDLE, sod=1, en=0, cls=0, s_ready=0, match_vec=0, result_valid=0.
REQ-028 sod SHALL fall at the first clock edge after rst_n deasserts.
REQ-029 Reset mid-packet SHALL discard the packet with no result reported.

Configuration
REQ-030 With PAYLOAD_FEEDER_NOCASE_EN defined, bytes 0x41-0x5A SHALL be folded to 0x61-0x7A before class lookup.
REQ-031 Without PAYLOAD_FEEDER_NOCASE_EN, lookup SHALL use the raw byte.

Structure
REQ-032 Package payload_class_pkg SHALL hold NUM_CLASS, a CLASS_TABLE of 256-bit membership maps, class index constants (CLS_DIGIT, CLS_WORD, CLS_SPACE, CLS_DOT, ...) and the FSM state enum.
REQ-033 Sub-module payload_class_lut SHALL provide the combinational byte-to-class-vector lookup, including case folding.

Verification
REQ-034 Reset held 3 cycles, then released -> sod=1 throughout reset, 0 after the first edge; all other outputs 0.
REQ-035 "STOR FKS_ab_1-2-3.log" streamed with s_last, with a model engine for /^STOR\s+FKS_\w+_\d+-\d+-\d+\.log/i -> its match_vec bit =1; result_valid at last-accept+3.
REQ-036 Same packet with the final "g" replaced by "x" -> match bit 0, same timing.
REQ-037 NOCASE_EN build, byte 0x53 'S' -> cls equals lut(0x73); non-NOCASE build -> lut(0x53).
REQ-038 s_valid toggled 1/0 every cycle mid-packet -> en mirrors accepted bytes; result identical to the gap-free run.
REQ-039 result_ready held 0 for 10 cycles -> match_vec stable, s_ready=0; next packet starts with sod after result_ready.
